sc_reg_bank: RTL and testbench
==============================

# sc_reg_bank

Parametrised bank of general-purpose registers, the multi-register successor to the single general register used in the datapath. It provides one write port with a per-cycle operation select (load, increment, decrement, clear-one) and two independent combinational read ports. It also provides registered carry and zero flags. It sits between the datapath ALU/bus and the control unit, replacing discrete register instances.

## Interface

Parameters:
- DATAWIDTH_BUS, 32: width of every register and data bus.
- ADDRWIDTH, 3: address width; the bank holds DEPTH = 2**ADDRWIDTH registers.

Ports:
- SC_RegBANK_CLOCK_50  in  1  system clock; all state changes on the rising edge.
- SC_RegBANK_RESET_InLow  in  1  reset, synchronous, active-low.
- SC_RegBANK_clear_InLow  in  1  synchronous clear of all registers and both flags, active-low.
- SC_RegBANK_write_InLow  in  1  write-port enable, active-low.
- SC_RegBANK_op_InBus  in  2  write operation: 00 load, 01 increment, 10 decrement, 11 clear-one.
- SC_RegBANK_waddr_InBus  in  ADDRWIDTH  write register address.
- SC_RegBANK_data_InBus  in  DATAWIDTH_BUS  load data; used only when op = 00.
- SC_RegBANK_raddrA_InBus  in  ADDRWIDTH  read port A address.
- SC_RegBANK_raddrB_InBus  in  ADDRWIDTH  read port B address.
- SC_RegBANK_dataA_OutBus  out  DATAWIDTH_BUS  contents of register raddrA.
- SC_RegBANK_dataB_OutBus  out  DATAWIDTH_BUS  contents of register raddrB.
- SC_RegBANK_carry_Out  out  1  registered carry (increment) or borrow (decrement) of the last write.
- SC_RegBANK_zero_Out  out  1  registered flag: the last written value was 0.

## Operation

- State is DEPTH registers of DATAWIDTH_BUS bits, plus the carry and zero flag flops.
- Priority at each rising edge, highest first: RESET_InLow = 0, then clear_InLow = 0, then write_InLow = 0, then hold.
- Reset or clear: all registers become 0, carry becomes 0, zero becomes 1.
- A write updates only register waddr; all other registers hold their value.
  - op 00 (load): reg ← data_InBus; carry ← 0.
  - op 01 (increment): reg ← reg + 1, modulo 2**DATAWIDTH_BUS; carry ← 1 only if reg was all-ones (wrap to 0).
  - op 10 (decrement): reg ← reg − 1, modulo 2**DATAWIDTH_BUS; carry ← 1 only if reg was 0 (wrap to all-ones).
  - op 11 (clear-one): reg ← 0; carry ← 0.
- On every write, zero ← (new value of reg waddr == 0).
- With no write and no clear, both flags hold their value.
- Increment and decrement read the stored value of waddr, never the bypassed value.
- Read ports are combinational muxes over the register array. Both ports may address the same register. Reads never alter state.
- Outputs after reset: dataA_OutBus = dataB_OutBus = 0, carry_Out = 0, zero_Out = 1.

## Timing

- Write latency is one cycle: the new value is visible on a read port in the cycle after the write edge. Without bypass, a read of waddr during the write cycle returns the old value.
- Read-to-output path is combinational, with zero cycles of latency.
- Flags update on the same edge as the register they describe.
- Reset asserted mid-sequence: the reset edge overrides any pending clear or write, and the write is lost.
- clear_InLow and write_InLow low in the same cycle: clear wins and the write is discarded.
- waddr is fully decoded; every address in 0..DEPTH−1 is valid, and there are no out-of-range cases.

## Configuration

- Macro SC_REGBANK_BYPASS_EN.
- Defined: write-to-read forwarding is compiled in.
  - When write_InLow = 0 and raddrA (or raddrB) == waddr, that port outputs the value that will be written at the next edge, in the same cycle.
  - When clear_InLow = 0, both ports output 0.
  - Reset has no bypass.
- Undefined: read ports always show the stored register contents.

## Test plan

- Reset, then read all addresses (DATAWIDTH_BUS = 8, ADDRWIDTH = 3) → every read is 0x00, carry = 0, zero = 1.
- Load 0xA5 into reg 3 and 0x3C into reg 5, then set raddrA = 3, raddrB = 5 in the next cycle → dataA = 0xA5, dataB = 0x3C, zero = 0, carry = 0.
- Load 0xFF into reg 2, then increment reg 2 → reg 2 = 0x00, carry = 1, zero = 1. Then decrement reg 2 → reg 2 = 0xFF, carry = 1, zero = 0.
- Hold clear_InLow and write_InLow low together with op 00, data 0x77, waddr 1 → after the edge all registers are 0 and reg 1 ≠ 0x77.
- Load reg 4 = 0x10. Then drive a write of 0x20 to reg 4 with raddrA = 4 in the same cycle.
  - With SC_REGBANK_BYPASS_EN: dataA = 0x20 during the write cycle.
  - Without it: dataA = 0x10.
  - Both builds: dataA = 0x20 the following cycle.
- Start a sequence of increments on reg 6 (0x00 → 0x01 → 0x02), then assert RESET_InLow while an increment is driven → next cycle reg 6 = 0x00, carry = 0, zero = 1.

Source files
------------

// File: rtl/sc_reg_bank.sv
// Multi-register general-purpose bank: one write port (load/inc/dec/clear-one),
// two combinational read ports, registered carry/zero flags. Optional forwarding: SC_REGBANK_BYPASS_EN.
module sc_reg_bank #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int ADDRWIDTH     = 3
) (
    input  logic                     SC_RegBANK_CLOCK_50,
    input  logic                     SC_RegBANK_RESET_InLow,
    input  logic                     SC_RegBANK_clear_InLow,
    input  logic                     SC_RegBANK_write_InLow,
    input  logic [1:0]               SC_RegBANK_op_InBus,
    input  logic [ADDRWIDTH-1:0]     SC_RegBANK_waddr_InBus,
    input  logic [DATAWIDTH_BUS-1:0] SC_RegBANK_data_InBus,
    input  logic [ADDRWIDTH-1:0]     SC_RegBANK_raddrA_InBus,
    input  logic [ADDRWIDTH-1:0]     SC_RegBANK_raddrB_InBus,
    output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_dataA_OutBus,
    output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_dataB_OutBus,
    output logic                     SC_RegBANK_carry_Out,
    output logic                     SC_RegBANK_zero_Out
);

    localparam int DEPTH = 2**ADDRWIDTH;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_INC   = 2'b01,
        OP_DEC   = 2'b10,
        OP_CLR1  = 2'b11
    } regOp_t;

    logic [DATAWIDTH_BUS-1:0] regFile [DEPTH];
    logic [DATAWIDTH_BUS-1:0] curValue;
    logic [DATAWIDTH_BUS-1:0] nextValue;
    logic                     nextCarry;
    regOp_t                   writeOp;

    assign writeOp  = regOp_t'(SC_RegBANK_op_InBus);
    assign curValue = regFile[SC_RegBANK_waddr_InBus];

    // Arithmetic always uses the stored value of waddr, never a forwarded one.
    always_comb begin
        nextValue = '0;
        nextCarry = 1'b0;
        case (writeOp)
            OP_LOAD: nextValue = SC_RegBANK_data_InBus;
            OP_INC: begin
                nextValue = curValue + 1'b1;
                nextCarry = &curValue;
            end
            OP_DEC: begin
                nextValue = curValue - 1'b1;
                nextCarry = ~|curValue;
            end
            OP_CLR1: nextValue = '0;
            default: nextValue = '0;
        endcase
    end

    always_ff @(posedge SC_RegBANK_CLOCK_50) begin
        if (!SC_RegBANK_RESET_InLow || !SC_RegBANK_clear_InLow) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regFile[i] <= '0;
            end
            SC_RegBANK_carry_Out <= 1'b0;
            SC_RegBANK_zero_Out  <= 1'b1;
        end else if (!SC_RegBANK_write_InLow) begin
            regFile[SC_RegBANK_waddr_InBus] <= nextValue;
            SC_RegBANK_carry_Out            <= nextCarry;
            SC_RegBANK_zero_Out             <= (nextValue == '0);
        end
    end

`ifdef SC_REGBANK_BYPASS_EN
    // Clear forces both ports to zero; a pending write forwards its next value.
    always_comb begin
        SC_RegBANK_dataA_OutBus = regFile[SC_RegBANK_raddrA_InBus];
        SC_RegBANK_dataB_OutBus = regFile[SC_RegBANK_raddrB_InBus];
        if (!SC_RegBANK_clear_InLow) begin
            SC_RegBANK_dataA_OutBus = '0;
            SC_RegBANK_dataB_OutBus = '0;
        end else if (!SC_RegBANK_write_InLow) begin
            if (SC_RegBANK_raddrA_InBus == SC_RegBANK_waddr_InBus)
                SC_RegBANK_dataA_OutBus = nextValue;
            if (SC_RegBANK_raddrB_InBus == SC_RegBANK_waddr_InBus)
                SC_RegBANK_dataB_OutBus = nextValue;
        end
    end
`else
    assign SC_RegBANK_dataA_OutBus = regFile[SC_RegBANK_raddrA_InBus];
    assign SC_RegBANK_dataB_OutBus = regFile[SC_RegBANK_raddrB_InBus];
`endif

endmodule

// File: tb/tb_sc_reg_bank.sv
// Directed bench for sc_reg_bank with 8-bit registers and 8 entries.
module tb_sc_reg_bank;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rstN;
    logic          clrN;
    logic          wrN;
    logic [1:0]    op;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddrA;
    logic [AW-1:0] raddrB;
    logic [DW-1:0] dataA;
    logic [DW-1:0] dataB;
    logic          carry;
    logic          zero;

    int checks   = 0;
    int failures = 0;

    sc_reg_bank #(.DATAWIDTH_BUS(DW), .ADDRWIDTH(AW)) dut (
        .SC_RegBANK_CLOCK_50     (clk),
        .SC_RegBANK_RESET_InLow  (rstN),
        .SC_RegBANK_clear_InLow  (clrN),
        .SC_RegBANK_write_InLow  (wrN),
        .SC_RegBANK_op_InBus     (op),
        .SC_RegBANK_waddr_InBus  (waddr),
        .SC_RegBANK_data_InBus   (wdata),
        .SC_RegBANK_raddrA_InBus (raddrA),
        .SC_RegBANK_raddrB_InBus (raddrB),
        .SC_RegBANK_dataA_OutBus (dataA),
        .SC_RegBANK_dataB_OutBus (dataB),
        .SC_RegBANK_carry_Out    (carry),
        .SC_RegBANK_zero_Out     (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] o, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wrN = 1'b0; op = o; waddr = a; wdata = d;
        tick();
        wrN = 1'b1;
    endtask

    task automatic check_flags(input string name, input logic expC, input logic expZ);
        checks++;
        if (carry !== expC) begin
            failures++;
            $display("FAIL %s carry: got %b expected %b", name, carry, expC);
        end
        checks++;
        if (zero !== expZ) begin
            failures++;
            $display("FAIL %s zero: got %b expected %b", name, zero, expZ);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; clrN = 1'b1; wrN = 1'b1; op = 2'b00; waddr = '0; wdata = '0;
        raddrA = '0; raddrB = '0;
        tick(); tick();
        rstN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            raddrA = AW'(i); raddrB = AW'(7 - i);
            #1;
            checks++;
            if (dataA !== 8'h00 || dataB !== 8'h00) begin
                failures++;
                $display("FAIL reset_read[%0d]: got A=%h B=%h expected 00", i, dataA, dataB);
            end
        end
        check_flags("reset", 1'b0, 1'b1);
    endtask

    task automatic test_load_read();
        do_write(2'b00, 3'd3, 8'hA5);
        do_write(2'b00, 3'd5, 8'h3C);
        raddrA = 3'd3; raddrB = 3'd5;
        #1;
        checks++;
        if (dataA !== 8'hA5 || dataB !== 8'h3C) begin
            failures++;
            $display("FAIL load_read: got A=%h B=%h expected A=a5 B=3c", dataA, dataB);
        end
        check_flags("load", 1'b0, 1'b0);
        raddrB = 3'd3;
        #1;
        checks++;
        if (dataB !== 8'hA5) begin
            failures++;
            $display("FAIL same_addr_read: got B=%h expected a5", dataB);
        end
    endtask

    task automatic test_wrap();
        do_write(2'b00, 3'd2, 8'hFF);
        do_write(2'b01, 3'd2, 8'h55);
        raddrA = 3'd2;
        #1;
        checks++;
        if (dataA !== 8'h00) begin
            failures++;
            $display("FAIL inc_wrap: got %h expected 00", dataA);
        end
        check_flags("inc_wrap", 1'b1, 1'b1);
        do_write(2'b10, 3'd2, 8'h55);
        checks++;
        if (dataA !== 8'hFF) begin
            failures++;
            $display("FAIL dec_wrap: got %h expected ff", dataA);
        end
        check_flags("dec_wrap", 1'b1, 1'b0);
        do_write(2'b10, 3'd2, 8'h00);
        checks++;
        if (dataA !== 8'hFE) begin
            failures++;
            $display("FAIL dec_plain: got %h expected fe", dataA);
        end
        check_flags("dec_plain", 1'b0, 1'b0);
        do_write(2'b11, 3'd2, 8'h00);
        checks++;
        if (dataA !== 8'h00) begin
            failures++;
            $display("FAIL clear_one: got %h expected 00", dataA);
        end
        check_flags("clear_one", 1'b0, 1'b1);
        raddrA = 3'd3;
        #1;
        checks++;
        if (dataA !== 8'hA5) begin
            failures++;
            $display("FAIL other_hold: got %h expected a5", dataA);
        end
    endtask

    task automatic test_clear_priority();
        do_write(2'b01, 3'd5, 8'h00);
        clrN = 1'b0; wrN = 1'b0; op = 2'b00; waddr = 3'd1; wdata = 8'h77;
        tick();
        clrN = 1'b1; wrN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            raddrA = AW'(i);
            #1;
            checks++;
            if (dataA !== 8'h00) begin
                failures++;
                $display("FAIL clear_all[%0d]: got %h expected 00", i, dataA);
            end
        end
        check_flags("clear", 1'b0, 1'b1);
    endtask

    task automatic test_bypass();
        logic [DW-1:0] expSame;
`ifdef SC_REGBANK_BYPASS_EN
        expSame = 8'h20;
`else
        expSame = 8'h10;
`endif
        do_write(2'b00, 3'd4, 8'h10);
        raddrA = 3'd4;
        wrN = 1'b0; op = 2'b00; waddr = 3'd4; wdata = 8'h20;
        #1;
        checks++;
        if (dataA !== expSame) begin
            failures++;
            $display("FAIL write_cycle_read: got %h expected %h", dataA, expSame);
        end
        tick();
        wrN = 1'b1;
        #1;
        checks++;
        if (dataA !== 8'h20) begin
            failures++;
            $display("FAIL after_write_read: got %h expected 20", dataA);
        end
    endtask

    task automatic test_reset_midseq();
        raddrA = 3'd6;
        do_write(2'b01, 3'd6, 8'h00);
        do_write(2'b01, 3'd6, 8'h00);
        checks++;
        if (dataA !== 8'h02) begin
            failures++;
            $display("FAIL inc_seq: got %h expected 02", dataA);
        end
        check_flags("inc_seq", 1'b0, 1'b0);
        rstN = 1'b0; wrN = 1'b0; op = 2'b01; waddr = 3'd6;
        tick();
        rstN = 1'b1; wrN = 1'b1;
        #1;
        checks++;
        if (dataA !== 8'h00) begin
            failures++;
            $display("FAIL reset_midseq: got %h expected 00", dataA);
        end
        check_flags("reset_midseq", 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_wrap();
        test_clear_priority();
        test_bypass();
        test_reset_midseq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
